layer_ibuf: RTL and testbench

Per-layer input buffer: receiving end of the inter-layer stream that a layer's functional unit emits. Accepts an `i_start` handshake from the previous layer's functional unit, captures `input_size` words one per write-enable cycle, and presents them zero-padded across the vertical CIM tiles. It then pulses a start to the local crossbar/functional unit and holds the data stable until that compute completes. Its `o_busy` feeds the upstream functional unit's next-busy input.

---
 rtl/cim_pkg.sv | 18 +
 rtl/layer_ibuf_if.sv | 29 ++
 rtl/layer_ibuf_regfile.sv | 46 ++++
 rtl/layer_ibuf.sv | 114 +++++++++++
 tb/tb_layer_ibuf.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_pkg.sv
// Shared CIM package: layer input-buffer state type and the tile-count helper
// used by both the input buffer and the functional unit.
package cim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StFull,
        StIssue,
        StHold
    } t_layer_ibuf_state;

    // Number of tiles needed to cover num rows with den rows per tile.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/layer_ibuf_if.sv
// Stream/compute handshake bundle between the upstream functional unit, the
// layer input buffer and the local CIM unit.
interface layer_ibuf_if #(
    parameter int unsigned input_size    = 201,
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned datatype_size = 8,
    parameter int unsigned v_cim_tiles   = cim_pkg::ceil_div(input_size, xbar_size)
);

    logic                                                    i_start;
    logic                                                    i_we;
    logic [datatype_size-1:0]                                i_data;
    logic                                                    i_cim_busy;
    logic                                                    o_busy;
    logic                                                    o_cim_start;
    logic [v_cim_tiles-1:0][xbar_size-1:0][datatype_size-1:0] o_cim_data;
    logic                                                    o_err;

    modport master (
        output i_start, i_we, i_data, i_cim_busy,
        input  o_busy, o_cim_start, o_cim_data, o_err
    );

    modport slave (
        input  i_start, i_we, i_data, i_cim_busy,
        output o_busy, o_cim_start, o_cim_data, o_err
    );

endinterface

// File: rtl/layer_ibuf_regfile.sv
// Write-addressed word register array with synchronous clear, exposed as a
// zero-padded [tile][row] view for the crossbar tiles.
module layer_ibuf_regfile #(
    parameter int unsigned input_size    = 201,
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned datatype_size = 8,
    parameter int unsigned v_cim_tiles   = 1,
    parameter int unsigned addr_width    = $clog2(input_size + 1)
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    we,
    input  logic [addr_width-1:0]                                   waddr,
    input  logic [datatype_size-1:0]                                wdata,
    output logic [v_cim_tiles-1:0][xbar_size-1:0][datatype_size-1:0] tile_data
);

    logic [datatype_size-1:0] buf_q [input_size];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < input_size; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < input_size; k++) begin
                if (we && (waddr == addr_width'(k))) begin
                    buf_q[k] <= wdata;
                end
            end
        end
    end

    // Rows past the last word are constant zero, never stored.
    for (genvar t = 0; t < v_cim_tiles; t++) begin : g_tile
        for (genvar r = 0; r < xbar_size; r++) begin : g_row
            localparam int unsigned Idx = t * xbar_size + r;
            if (Idx < input_size) begin : g_word
                assign tile_data[t][r] = buf_q[Idx];
            end else begin : g_pad
                assign tile_data[t][r] = '0;
            end
        end
    end

endmodule

// File: rtl/layer_ibuf.sv
// Per-layer input buffer: captures one streamed vector, starts the local CIM
// and holds the data until it finishes. Define LAYER_IBUF_PROTO_CHECK_EN for o_err.
module layer_ibuf
    import cim_pkg::*;
#(
    parameter int unsigned input_size    = 201,
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned datatype_size = 8,
    parameter int unsigned v_cim_tiles   = ceil_div(input_size, xbar_size)
) (
    input logic         clk,
    input logic         rst,
    layer_ibuf_if.slave bus
);

    localparam int unsigned CntW = $clog2(input_size + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(input_size - 1);

    t_layer_ibuf_state state_q, state_d;
    logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic              buf_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_cnt_q    <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        seen_busy_d = seen_busy_q;
        buf_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d  = StFill;
                    wr_cnt_d = '0;
                end
            end
            StFill: begin
                if (bus.i_we) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + CntW'(1);
                    if (wr_cnt_q == LastIdx) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (!bus.i_cim_busy) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                seen_busy_d = 1'b0;
                state_d     = StHold;
            end
            StHold: begin
                if (bus.i_cim_busy) begin
                    seen_busy_d = 1'b1;
                end
                // Done only once the CIM has been seen busy and has dropped again.
                if (seen_busy_q && !bus.i_cim_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_cim_start = (state_q == StIssue);

    layer_ibuf_regfile #(
        .input_size   (input_size),
        .xbar_size    (xbar_size),
        .datatype_size(datatype_size),
        .v_cim_tiles  (v_cim_tiles),
        .addr_width   (CntW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (buf_we),
        .waddr    (wr_cnt_q),
        .wdata    (bus.i_data),
        .tile_data(bus.o_cim_data)
    );

`ifdef LAYER_IBUF_PROTO_CHECK_EN
    logic err_q;

    // Start+write together in idle is caught by the write-outside-fill term.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((bus.i_we && (state_q != StFill)) || (bus.i_start && (state_q != StIdle))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_ibuf.sv
// Self-checking bench for layer_ibuf with a small vector (5 words, 4-row tiles),
// compared against a word-array model of the expected tile view.
module tb_layer_ibuf;

    localparam int unsigned IS = 5;
    localparam int unsigned XS = 4;
    localparam int unsigned DS = 8;
    localparam int unsigned VT = 2;

    typedef logic [VT-1:0][XS-1:0][DS-1:0] t_view;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DS-1:0] ref_mem [IS];

    layer_ibuf_if #(.input_size(IS), .xbar_size(XS), .datatype_size(DS)) bus ();

    layer_ibuf #(
        .input_size   (IS),
        .xbar_size    (XS),
        .datatype_size(DS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
        $fatal(1, "watchdog");
    end

    // Expected tile view: word k lands at tile k/XS, row k%XS; rest is zero.
    function automatic t_view exp_view();
        t_view v;
        for (int t = 0; t < VT; t++) begin
            for (int r = 0; r < XS; r++) begin
                int idx;
                idx = t * XS + r;
                v[t][r] = (idx < IS) ? ref_mem[idx] : '0;
            end
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_start    = 1'b0;
        bus.i_we       = 1'b0;
        bus.i_data     = '0;
        bus.i_cim_busy = 1'b0;
        rst            = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic randomize_ref();
        for (int k = 0; k < IS; k++) ref_mem[k] = DS'($urandom);
    endtask

    task automatic begin_vec();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    // Streams ref_mem with up to gap_max idle cycles (junk data) before each word.
    task automatic fill_vec(input int gap_max);
        for (int k = 0; k < IS; k++) begin
            int gaps;
            gaps = $urandom_range(gap_max, 0);
            for (int g = 0; g < gaps; g++) begin
                bus.i_we   = 1'b0;
                bus.i_data = DS'($urandom);
                step();
            end
            bus.i_we   = 1'b1;
            bus.i_data = ref_mem[k];
            step();
        end
        bus.i_we = 1'b0;
    endtask

    // Called while o_cim_start is high; CIM busy for n cycles after the start.
    task automatic drain(input int n, output int lat);
        step();
        bus.i_cim_busy = 1'b1;
        repeat (n) step();
        bus.i_cim_busy = 1'b0;
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (!bus.o_busy) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy: got %b, required 0", bus.o_busy);
        end
        n_checks++;
        if (bus.o_cim_start !== 1'b0) begin
            n_errors++; $display("FAIL reset_start: got %b, required 0", bus.o_cim_start);
        end
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_err: got %b, required 0", bus.o_err);
        end
        n_checks++;
        if (bus.o_cim_data !== t_view'('0)) begin
            n_errors++; $display("FAIL reset_data: got %h, required 0", bus.o_cim_data);
        end
    endtask

    task automatic test_basic_fill();
        int lat;
        int starts;
        do_reset();
        for (int k = 0; k < IS; k++) ref_mem[k] = DS'(k + 1);
        begin_vec();
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_errors++; $display("FAIL basic_busy_after_start: got %b, required 1", bus.o_busy);
        end
        starts = 0;
        for (int k = 0; k < IS; k++) begin
            bus.i_we   = 1'b1;
            bus.i_data = ref_mem[k];
            step();
            if (bus.o_cim_start) starts++;
        end
        bus.i_we = 1'b0;
        n_checks++;
        if (starts !== 0) begin
            n_errors++; $display("FAIL basic_early_start: got %0d pulses, required 0", starts);
        end
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b1) begin
            n_errors++; $display("FAIL basic_start_pulse: got %b, required 1", bus.o_cim_start);
        end
        n_checks++;
        if (bus.o_cim_data !== exp_view()) begin
            n_errors++;
            $display("FAIL basic_data: got %h, required %h", bus.o_cim_data, exp_view());
        end
        n_checks++;
        if (bus.o_cim_data[1] !== {8'd0, 8'd0, 8'd0, 8'd5}) begin
            n_errors++; $display("FAIL basic_pad_tile: got %h, required 00000005", bus.o_cim_data[1]);
        end
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b0) begin
            n_errors++; $display("FAIL basic_start_one_cycle: got %b, required 0", bus.o_cim_start);
        end
        bus.i_cim_busy = 1'b1;
        step();
        bus.i_cim_busy = 1'b0;
        step();
        lat = bus.o_busy ? 1 : 0;
        n_checks++;
        if (lat !== 0) begin
            n_errors++; $display("FAIL basic_release: got busy=%0d, required 0", lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset();
        randomize_ref();
        begin_vec();
        bus.i_cim_busy = 1'b1;
        fill_vec(1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.o_busy !== 1'b1 || bus.o_cim_start !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_stall[%0d]: got busy=%b start=%b, required busy=1 start=0",
                         i, bus.o_busy, bus.o_cim_start);
            end
            step();
        end
        bus.i_cim_busy = 1'b0;
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b1) begin
            n_errors++; $display("FAIL bp_start_after_release: got %b, required 1", bus.o_cim_start);
        end
        n_checks++;
        if (bus.o_cim_data !== exp_view()) begin
            n_errors++; $display("FAIL bp_data: got %h, required %h", bus.o_cim_data, exp_view());
        end
        drain(1, lat);
        n_checks++;
        if (lat !== 1) begin
            n_errors++; $display("FAIL bp_drain_latency: got %0d, required 1", lat);
        end
    endtask

    task automatic test_hold();
        do_reset();
        randomize_ref();
        begin_vec();
        fill_vec(0);
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b1) begin
            n_errors++; $display("FAIL hold_start: got %b, required 1", bus.o_cim_start);
        end
        step();
        bus.i_cim_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_data = DS'($urandom);
            step();
            n_checks++;
            if (bus.o_busy !== 1'b1 || bus.o_cim_data !== exp_view()) begin
                n_errors++;
                $display("FAIL hold_stable[%0d]: got busy=%b data=%h, required busy=1 data=%h",
                         i, bus.o_busy, bus.o_cim_data, exp_view());
            end
        end
        bus.i_cim_busy = 1'b0;
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_errors++; $display("FAIL hold_busy_same_cycle: got %b, required 1", bus.o_busy);
        end
        step();
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_errors++; $display("FAIL hold_busy_fall: got %b, required 0", bus.o_busy);
        end
        n_checks++;
        if (bus.o_cim_data !== exp_view()) begin
            n_errors++; $display("FAIL hold_data_idle: got %h, required %h", bus.o_cim_data, exp_view());
        end
    endtask

    task automatic test_gapped();
        int k;
        int starts;
        int lat;
        do_reset();
        randomize_ref();
        begin_vec();
        k = 0;
        starts = 0;
        for (int c = 0; c < 2 * IS - 1; c++) begin
            if (c % 2 == 0) begin
                bus.i_we   = 1'b1;
                bus.i_data = ref_mem[k];
                k++;
            end else begin
                bus.i_we   = 1'b0;
                bus.i_data = DS'($urandom);
            end
            step();
            if (bus.o_cim_start) starts++;
        end
        bus.i_we = 1'b0;
        n_checks++;
        if (starts !== 0) begin
            n_errors++; $display("FAIL gap_early_start: got %0d pulses, required 0", starts);
        end
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b1) begin
            n_errors++; $display("FAIL gap_start: got %b, required 1", bus.o_cim_start);
        end
        n_checks++;
        if (bus.o_cim_data !== exp_view()) begin
            n_errors++; $display("FAIL gap_data: got %h, required %h", bus.o_cim_data, exp_view());
        end
        drain(2, lat);
        n_checks++;
        if (lat !== 1) begin
            n_errors++; $display("FAIL gap_drain_latency: got %0d, required 1", lat);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        do_reset();
        randomize_ref();
        begin_vec();
        for (int k = 0; k < 3; k++) begin
            bus.i_we   = 1'b1;
            bus.i_data = ref_mem[k];
            step();
        end
        bus.i_we = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_cim_start !== 1'b0 || bus.o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_ctrl: got busy=%b start=%b err=%b, required all 0",
                     bus.o_busy, bus.o_cim_start, bus.o_err);
        end
        n_checks++;
        if (bus.o_cim_data !== t_view'('0)) begin
            n_errors++; $display("FAIL midrst_data: got %h, required 0", bus.o_cim_data);
        end
        randomize_ref();
        begin_vec();
        fill_vec(2);
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b1 || bus.o_cim_data !== exp_view()) begin
            n_errors++;
            $display("FAIL midrst_refill: got start=%b data=%h, required start=1 data=%h",
                     bus.o_cim_start, bus.o_cim_data, exp_view());
        end
        drain(1, lat);
        n_checks++;
        if (lat !== 1) begin
            n_errors++; $display("FAIL midrst_drain_latency: got %0d, required 1", lat);
        end
    endtask

    task automatic test_ignored_inputs();
        int lat;
        do_reset();
        bus.i_we   = 1'b1;
        bus.i_data = 8'hAA;
        step();
        step();
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_cim_data !== t_view'('0)) begin
            n_errors++;
            $display("FAIL ign_we_idle: got busy=%b data=%h, required busy=0 data=0",
                     bus.o_busy, bus.o_cim_data);
        end
        // Start and write together: the word must be dropped.
        bus.i_start = 1'b1;
        bus.i_data  = 8'h55;
        step();
        bus.i_start = 1'b0;
        bus.i_we    = 1'b0;
        n_checks++;
        if (bus.o_cim_data !== t_view'('0)) begin
            n_errors++; $display("FAIL ign_start_we: got %h, required 0", bus.o_cim_data);
        end
        randomize_ref();
        bus.i_cim_busy = 1'b1;
        for (int k = 0; k < IS; k++) begin
            bus.i_start = 1'b1;
            bus.i_we    = 1'b1;
            bus.i_data  = ref_mem[k];
            step();
        end
        bus.i_start = 1'b0;
        // Held in full by backpressure; writes now must not land.
        for (int i = 0; i < 3; i++) begin
            bus.i_we   = 1'b1;
            bus.i_data = DS'($urandom);
            step();
        end
        bus.i_we = 1'b0;
        n_checks++;
        if (bus.o_cim_data !== exp_view() || bus.o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL ign_we_full: got busy=%b data=%h, required busy=1 data=%h",
                     bus.o_busy, bus.o_cim_data, exp_view());
        end
        bus.i_cim_busy = 1'b0;
        step();
        n_checks++;
        if (bus.o_cim_start !== 1'b1) begin
            n_errors++; $display("FAIL ign_start: got %b, required 1", bus.o_cim_start);
        end
        drain(1, lat);
        n_checks++;
        if (lat !== 1) begin
            n_errors++; $display("FAIL ign_drain_latency: got %0d, required 1", lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bp;
        do_reset();
        for (int v = 0; v < 6; v++) begin
            randomize_ref();
            bp = $urandom_range(3, 0);
            begin_vec();
            bus.i_cim_busy = (bp > 0);
            fill_vec(2);
            for (int i = 0; i < bp; i++) begin
                n_checks++;
                if (bus.o_cim_start !== 1'b0 || bus.o_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_stall[%0d]: got start=%b busy=%b, required start=0 busy=1",
                             v, bus.o_cim_start, bus.o_busy);
                end
                step();
            end
            bus.i_cim_busy = 1'b0;
            step();
            n_checks++;
            if (bus.o_cim_start !== 1'b1 || bus.o_cim_data !== exp_view()) begin
                n_errors++;
                $display("FAIL b2b_vec[%0d]: got start=%b data=%h, required start=1 data=%h",
                         v, bus.o_cim_start, bus.o_cim_data, exp_view());
            end
            drain(int'($urandom_range(3, 1)), lat);
            n_checks++;
            if (lat !== 1) begin
                n_errors++; $display("FAIL b2b_drain[%0d]: got %0d, required 1", v, lat);
            end
        end
    endtask

`ifdef LAYER_IBUF_PROTO_CHECK_EN
    task automatic test_proto_err();
        do_reset();
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            n_errors++; $display("FAIL err_clear: got %b, required 0", bus.o_err);
        end
        bus.i_we   = 1'b1;
        bus.i_data = 8'h3C;
        step();
        bus.i_we = 1'b0;
        n_checks++;
        if (bus.o_err !== 1'b1) begin
            n_errors++; $display("FAIL err_set: got %b, required 1", bus.o_err);
        end
        repeat (3) step();
        n_checks++;
        if (bus.o_err !== 1'b1 || bus.o_cim_data !== t_view'('0)) begin
            n_errors++;
            $display("FAIL err_sticky: got err=%b data=%h, required err=1 data=0",
                     bus.o_err, bus.o_cim_data);
        end
        do_reset();
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            n_errors++; $display("FAIL err_reset: got %b, required 0", bus.o_err);
        end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_we       = 1'b0;
        bus.i_data     = '0;
        bus.i_cim_busy = 1'b0;
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_hold();
        test_gapped();
        test_reset_mid_fill();
        test_ignored_inputs();
        test_back_to_back();
`ifdef LAYER_IBUF_PROTO_CHECK_EN
        test_proto_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
